axi_stream_extract_header: RTL and testbench

// Receive-side counterpart of the header inserter. Strips the first (byte_extract_cnt+1) bytes of each
// AXI-Stream packet onto a separate header channel. Re-packs the remaining payload into full, MSB-aligned beats.

---
 rtl/axi_stream_extract_header.sv | 184 ++++++++++++++++++
 tb/tb_axi_stream_extract_header.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_stream_extract_header.sv
// Receive-side header extractor: peels the first H bytes of each AXI-Stream packet onto a
// header channel and re-packs the remaining payload into full, MSB-aligned beats.

module axi_stream_extract_header_lane (
  input  logic [7:0] byte_in,
  input  logic       en,
  output logic [7:0] byte_out
);
  assign byte_out = en ? byte_in : 8'h00;
endmodule

module axi_stream_extract_header #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  input  logic                    valid_extract,
  input  logic [BYTE_CNT_WD-1:0]  byte_extract_cnt,
  output logic                    ready_extract,
  output logic                    valid_header,
  output logic [DATA_WD-1:0]      data_header,
  output logic [DATA_BYTE_WD-1:0] keep_header,
  output logic                    header_short,
  input  logic                    ready_header,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out
);
  localparam int N  = DATA_BYTE_WD;
  localparam int CW = BYTE_CNT_WD + 1;
  localparam logic [CW-1:0] N_C = CW'(N);
  localparam logic [CW:0]   N_T = (CW+1)'(N);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BODY = 2'd1;
  localparam logic [1:0] S_TAIL = 2'd2;

  logic [1:0]         state;
  logic [DATA_WD-1:0] res_data;
  logic [CW-1:0]      res_cnt;

  logic [N-1:0][7:0]  din_lanes;
  logic [DATA_WD-1:0] din_m;
  logic [CW-1:0]      k_cnt, h_cnt, nh;
  logic [CW:0]        tot, tail_cnt;
  logic [DATA_WD-1:0] hdr_data, idle_res, body_data, body_res;
  logic [N-1:0]       hdr_keep, idle_keep;
  logic               hdr_free, pay_free, idle_go, acc;

  function automatic logic [N-1:0] therm(input logic [CW:0] c);
    therm = ~({N{1'b1}} >> c);
  endfunction

  // zero every byte whose keep bit is clear before it reaches any output path
  for (genvar i = 0; i < N; i++) begin : g_lane
    axi_stream_extract_header_lane u_lane (
      .byte_in (data_in[8*i +: 8]),
      .en      (keep_in[i]),
      .byte_out(din_lanes[i])
    );
  end
  assign din_m = din_lanes;

  always_comb begin
    k_cnt = '0;
    for (int i = 0; i < N; i++) k_cnt = k_cnt + CW'(keep_in[i]);
  end

  assign h_cnt     = CW'(byte_extract_cnt) + CW'(1);
  assign nh        = N_C - h_cnt;
  assign hdr_data  = din_m >> {nh, 3'b000};
  assign hdr_keep  = keep_in >> nh;
  assign idle_res  = din_m << {h_cnt, 3'b000};
  assign idle_keep = keep_in << h_cnt;

  // residual occupies the top res_cnt bytes; the new beat slides in right behind it
  assign tot       = {1'b0, res_cnt} + {1'b0, k_cnt};
  assign tail_cnt  = tot - N_T;
  assign body_data = res_data | (din_m >> {res_cnt, 3'b000});
  assign body_res  = din_m << {N_C - res_cnt, 3'b000};

  assign hdr_free = !valid_header || ready_header;
  assign pay_free = !valid_out || ready_out;
  assign idle_go  = valid_in && valid_extract && hdr_free && pay_free;

  always_comb begin
    ready_in      = 1'b0;
    ready_extract = 1'b0;
    if (!rst) begin
      case (state)
        S_IDLE: begin
          ready_in      = idle_go;
          ready_extract = idle_go;
        end
        S_BODY:  ready_in = pay_free;
        default: ;
      endcase
    end
  end

  assign acc = valid_in && ready_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      res_data     <= '0;
      res_cnt      <= '0;
      valid_header <= 1'b0;
      data_header  <= '0;
      keep_header  <= '0;
      header_short <= 1'b0;
      valid_out    <= 1'b0;
      data_out     <= '0;
      keep_out     <= '0;
      last_out     <= 1'b0;
    end else begin
      if (valid_header && ready_header) valid_header <= 1'b0;
      if (valid_out && ready_out)       valid_out    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (acc) begin
            valid_header <= 1'b1;
            data_header  <= hdr_data;
            keep_header  <= hdr_keep;
            header_short <= last_in && (k_cnt < h_cnt);
            if (last_in) begin
              if (k_cnt > h_cnt) begin
                valid_out <= 1'b1;
                data_out  <= idle_res;
                keep_out  <= idle_keep;
                last_out  <= 1'b1;
              end
            end else begin
              res_data <= idle_res;
              res_cnt  <= nh;
              state    <= S_BODY;
            end
          end
        end
        S_BODY: begin
          if (acc) begin
            valid_out <= 1'b1;
            data_out  <= body_data;
            if (last_in && (tot <= N_T)) begin
              keep_out <= therm(tot);
              last_out <= 1'b1;
              res_data <= '0;
              res_cnt  <= '0;
              state    <= S_IDLE;
            end else begin
              keep_out <= '1;
              last_out <= 1'b0;
              res_data <= body_res;
              res_cnt  <= tail_cnt[CW-1:0];
              if (last_in) state <= S_TAIL;
            end
          end
        end
        S_TAIL: begin
          if (pay_free) begin
            valid_out <= 1'b1;
            data_out  <= res_data;
            keep_out  <= therm({1'b0, res_cnt});
            last_out  <= 1'b1;
            res_data  <= '0;
            res_cnt   <= '0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_stream_extract_header.sv
// Bench for axi_stream_extract_header: directed vector table, tail/reset sequences and a
// random packet stream, all checked through header/payload scoreboards.

module tb_axi_stream_extract_header;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_in = 1'b0;
  logic [31:0] data_in = '0;
  logic [3:0]  keep_in = '0;
  logic        last_in = 1'b0;
  logic        ready_in;
  logic        valid_extract = 1'b0;
  logic [1:0]  byte_extract_cnt = '0;
  logic        ready_extract;
  logic        valid_header;
  logic [31:0] data_header;
  logic [3:0]  keep_header;
  logic        header_short;
  logic        ready_header = 1'b1;
  logic        valid_out;
  logic [31:0] data_out;
  logic [3:0]  keep_out;
  logic        last_out;
  logic        ready_out = 1'b1;

  always #5 clk = ~clk;

  axi_stream_extract_header #(.DATA_WD(32)) dut (
    .clk(clk), .rst(rst),
    .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in), .ready_in(ready_in),
    .valid_extract(valid_extract), .byte_extract_cnt(byte_extract_cnt), .ready_extract(ready_extract),
    .valid_header(valid_header), .data_header(data_header), .keep_header(keep_header),
    .header_short(header_short), .ready_header(ready_header),
    .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out),
    .ready_out(ready_out)
  );

  typedef struct packed { logic [31:0] d; logic [3:0] k; logic s; } hdr_t;
  typedef struct packed { logic [31:0] d; logic [3:0] k; logic l; } pay_t;
  typedef struct packed {
    logic [1:0]       cnt;
    int               len;
    hdr_t             h;
    int               nout;
    logic [2:0][31:0] od;
    logic [2:0][3:0]  ok;
  } vec_t;

  hdr_t       hdr_q[$];
  pay_t       pay_q[$];
  vec_t       vecs[$];
  logic [7:0] pkt[$];
  int         n_vec = 0;
  int         n_fail = 0;
  logic       rnd_mode = 1'b0;
  logic       hold_h = 1'b0, hold_o = 1'b0;
  hdr_t       hh;
  pay_t       ho;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  task automatic add_vec(input logic [1:0] cnt, input int len, input logic [31:0] hd, input logic [3:0] hk,
                         input logic hs, input int nout,
                         input logic [31:0] o0, input logic [3:0] k0, input logic [31:0] o1, input logic [3:0] k1,
                         input logic [31:0] o2, input logic [3:0] k2);
    vec_t v;
    v.cnt = cnt; v.len = len; v.h.d = hd; v.h.k = hk; v.h.s = hs; v.nout = nout;
    v.od[0] = o0; v.ok[0] = k0; v.od[1] = o1; v.ok[1] = k1; v.od[2] = o2; v.ok[2] = k2;
    vecs.push_back(v);
  endtask

  // packet bytes A0 A1 A2 A3 B0 B1 ... (beat letter in the high nibble, position in the low)
  task automatic fill_seq(input int len);
    pkt.delete();
    for (int i = 0; i < len; i++) pkt.push_back(8'(160 + 16*(i/4) + i%4));
  endtask

  task automatic load_vec(input vec_t v);
    fill_seq(v.len);
    hdr_q.push_back(v.h);
    for (int i = 0; i < v.nout; i++) begin
      pay_t p;
      p.d = v.od[i]; p.k = v.ok[i]; p.l = (i == v.nout - 1);
      pay_q.push_back(p);
    end
  endtask

  // reference: header = first min(len,H) bytes placed at positions N-H.., payload = rest in 4-byte chunks
  task automatic push_model(input int h, input int len);
    hdr_t eh;
    int   n;
    eh.d = '0; eh.k = '0; eh.s = (len < h);
    n = (len < h) ? len : h;
    for (int j = 0; j < n; j++) begin
      eh.d[31 - 8*(4-h+j) -: 8] = pkt[j];
      eh.k[3 - (4-h+j)] = 1'b1;
    end
    hdr_q.push_back(eh);
    for (int s = h; s < len; s += 4) begin
      pay_t ep;
      ep.d = '0; ep.k = '0; ep.l = (s + 4 >= len);
      for (int j = 0; j < 4; j++)
        if (s + j < len) begin
          ep.d[31 - 8*j -: 8] = pkt[s+j];
          ep.k[3 - j] = 1'b1;
        end
      pay_q.push_back(ep);
    end
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l, input logic first,
                           input logic [1:0] cnt, input int gap);
    int   t;
    logic acc;
    repeat (gap) begin
      @(negedge clk);
      valid_in = 1'b0; valid_extract = 1'b0;
    end
    @(negedge clk);
    valid_in = 1'b1; data_in = d; keep_in = k; last_in = l;
    valid_extract = first;
    byte_extract_cnt = first ? cnt : 2'($urandom);
    t = 0; acc = 1'b0;
    while (!acc && t < 300) begin
      #1;
      acc = ready_in;
      @(posedge clk);
      if (!acc) begin
        @(negedge clk);
        t++;
      end
    end
    if (!acc) begin
      n_vec++; n_fail++;
      $display("FAIL accept_timeout: got no ready_in in %0d cycles, expected acceptance", t);
    end
  endtask

  task automatic send_pkt(input logic [1:0] cnt, input int len, input logic rnd);
    int nb;
    nb = (len + 3) / 4;
    for (int b = 0; b < nb; b++) begin
      logic [31:0] d;
      logic [3:0]  k;
      d = $urandom; k = '0;
      for (int j = 0; j < 4; j++)
        if (b*4 + j < len) begin
          d[31 - 8*j -: 8] = pkt[b*4 + j];
          k[3 - j] = 1'b1;
        end
      send_beat(d, k, (b == nb - 1), (b == 0), cnt, rnd ? $urandom_range(0, 2) : 0);
    end
  endtask

  task automatic idle_in();
    @(negedge clk);
    valid_in = 1'b0; valid_extract = 1'b0;
  endtask

  task automatic drain(input string nm);
    int t;
    t = 0;
    while ((hdr_q.size() != 0 || pay_q.size() != 0) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    chk(nm, 64'(hdr_q.size() + pay_q.size()), 64'd0);
  endtask

  task automatic mon_step();
    hdr_t ah, eh;
    pay_t ap, ep;
    @(negedge clk);
    ready_out    = rnd_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
    ready_header = rnd_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
    #1;
    ah.d = data_header; ah.k = keep_header; ah.s = header_short;
    ap.d = data_out;    ap.k = keep_out;    ap.l = last_out;
    if (rst) begin
      hold_h = 1'b0; hold_o = 1'b0;
    end else begin
      if (hold_o) begin
        n_vec++;
        if (!valid_out || ap !== ho) begin
          n_fail++;
          $display("FAIL stall_payload: got v=%0b %h/%h/%0b, expected held %h/%h/%0b",
                   valid_out, ap.d, ap.k, ap.l, ho.d, ho.k, ho.l);
        end
      end
      if (hold_h) begin
        n_vec++;
        if (!valid_header || ah !== hh) begin
          n_fail++;
          $display("FAIL stall_header: got v=%0b %h/%h/%0b, expected held %h/%h/%0b",
                   valid_header, ah.d, ah.k, ah.s, hh.d, hh.k, hh.s);
        end
      end
      hold_o = valid_out && !ready_out;       ho = ap;
      hold_h = valid_header && !ready_header; hh = ah;
      if (valid_out && ready_out) begin
        n_vec++;
        if (pay_q.size() == 0) begin
          n_fail++;
          $display("FAIL payload_extra: got %h/%h last=%0b, expected no beat", ap.d, ap.k, ap.l);
        end else begin
          ep = pay_q.pop_front();
          if (ap !== ep) begin
            n_fail++;
            $display("FAIL payload: got %h/%h last=%0b, expected %h/%h last=%0b", ap.d, ap.k, ap.l, ep.d, ep.k, ep.l);
          end
        end
      end
      if (valid_header && ready_header) begin
        n_vec++;
        if (hdr_q.size() == 0) begin
          n_fail++;
          $display("FAIL header_extra: got %h/%h short=%0b, expected no header", ah.d, ah.k, ah.s);
        end else begin
          eh = hdr_q.pop_front();
          if (ah !== eh) begin
            n_fail++;
            $display("FAIL header: got %h/%h short=%0b, expected %h/%h short=%0b", ah.d, ah.k, ah.s, eh.d, eh.k, eh.s);
          end
        end
      end
    end
  endtask

  initial begin
    //      cnt len  hdr data      keep  short nout  payload beats
    add_vec(2'd1, 12, 32'h0000A0A1, 4'h3, 1'b0, 3, 32'hA2A3B0B1, 4'hF, 32'hB2B3C0C1, 4'hF, 32'hC2C30000, 4'hC);
    add_vec(2'd3,  5, 32'hA0A1A2A3, 4'hF, 1'b0, 1, 32'hB0000000, 4'h8, 32'h0,        4'h0, 32'h0,        4'h0);
    add_vec(2'd0,  7, 32'h000000A0, 4'h1, 1'b0, 2, 32'hA1A2A3B0, 4'hF, 32'hB1B20000, 4'hC, 32'h0,        4'h0);
    add_vec(2'd3,  2, 32'hA0A10000, 4'hC, 1'b1, 0, 32'h0,        4'h0, 32'h0,        4'h0, 32'h0,        4'h0);
    add_vec(2'd3,  4, 32'hA0A1A2A3, 4'hF, 1'b0, 0, 32'h0,        4'h0, 32'h0,        4'h0, 32'h0,        4'h0);
    add_vec(2'd0,  1, 32'h000000A0, 4'h1, 1'b0, 0, 32'h0,        4'h0, 32'h0,        4'h0, 32'h0,        4'h0);
    add_vec(2'd1,  3, 32'h0000A0A1, 4'h3, 1'b0, 1, 32'hA2000000, 4'h8, 32'h0,        4'h0, 32'h0,        4'h0);
    add_vec(2'd2,  8, 32'h00A0A1A2, 4'h7, 1'b0, 2, 32'hA3B0B1B2, 4'hF, 32'hB3000000, 4'h8, 32'h0,        4'h0);
    add_vec(2'd3,  8, 32'hA0A1A2A3, 4'hF, 1'b0, 1, 32'hB0B1B2B3, 4'hF, 32'h0,        4'h0, 32'h0,        4'h0);

    fork
      forever mon_step();
      begin
        #900000;
        $display("FAIL watchdog: got time limit after %0d vectors, expected completion", n_vec);
        $fatal(1, "watchdog expired");
      end
    join_none

    // reset state, with inputs offering a beat the whole time
    repeat (3) @(posedge clk);
    @(negedge clk);
    valid_in = 1'b1; valid_extract = 1'b1; data_in = 32'h11223344; keep_in = 4'hF;
    #1;
    chk("rst_ready_in", 64'(ready_in), 64'd0);
    chk("rst_ready_extract", 64'(ready_extract), 64'd0);
    chk("rst_flags", 64'({valid_header, valid_out, last_out, header_short}), 64'd0);
    chk("rst_data", {data_header, data_out}, 64'd0);
    chk("rst_keep", 64'({keep_header, keep_out}), 64'd0);
    valid_in = 1'b0; valid_extract = 1'b0; rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      load_vec(vecs[i]);
      send_pkt(vecs[i].cnt, vecs[i].len, 1'b0);
    end
    idle_in();
    drain("directed_drain");

    // tail cycle blocks input, then IDLE offers ready again
    load_vec(vecs[0]);
    send_pkt(vecs[0].cnt, vecs[0].len, 1'b0);
    @(negedge clk);
    valid_in = 1'b1; valid_extract = 1'b1;
    #1;
    chk("tail_ready_in", 64'(ready_in), 64'd0);
    chk("tail_ready_extract", 64'(ready_extract), 64'd0);
    @(negedge clk);
    #1;
    chk("idle_after_tail", 64'(ready_in), 64'd1);
    #1;
    valid_in = 1'b0; valid_extract = 1'b0;
    drain("tail_drain");

    rnd_mode = 1'b1;
    for (int p = 0; p < 200; p++) begin
      logic [1:0] c;
      int         len;
      c = 2'($urandom);
      len = $urandom_range(1, 13);
      pkt.delete();
      for (int i = 0; i < len; i++) pkt.push_back(8'($urandom));
      push_model(int'(c) + 1, len);
      send_pkt(c, len, 1'b1);
    end
    idle_in();
    rnd_mode = 1'b0;
    drain("random_drain");

    // reset in the middle of a packet body
    hdr_q.push_back(hdr_t'{d: 32'h0000A0A1, k: 4'h3, s: 1'b0});
    pay_q.push_back(pay_t'{d: 32'hA2A3B0B1, k: 4'hF, l: 1'b0});
    send_beat(32'hA0A1A2A3, 4'hF, 1'b0, 1'b1, 2'd1, 0);
    send_beat(32'hB0B1B2B3, 4'hF, 1'b0, 1'b0, 2'd1, 0);
    @(negedge clk);
    valid_in = 1'b0;
    #2;
    rst = 1'b1;
    @(negedge clk);
    valid_in = 1'b1; valid_extract = 1'b1;
    #2;
    chk("rst_mid_valids", 64'({valid_header, valid_out}), 64'd0);
    chk("rst_mid_ready", 64'({ready_in, ready_extract}), 64'd0);
    chk("rst_mid_queue", 64'(hdr_q.size() + pay_q.size()), 64'd0);
    rst = 1'b0; valid_in = 1'b0; valid_extract = 1'b0;

    load_vec(vecs[0]);
    send_pkt(vecs[0].cnt, vecs[0].len, 1'b0);
    idle_in();
    drain("post_rst_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
